state_commit: RTL

STATE_COMMIT -- requirements
Module: state_commit

---
 rtl/state_commit_pkg.sv | 18 +
 rtl/commit_time_acc.sv | 96 +++++++++
 rtl/state_commit.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/state_commit_pkg.sv
// -----------------------------------------------------------------------------
// state_commit_pkg
// Shared definitions for the state_commit block: default word/address widths
// and the copy-and-commit FSM state encoding.
// -----------------------------------------------------------------------------
package state_commit_pkg;

  localparam int unsigned WORD_W = 16;  // default data / time / step width
  localparam int unsigned ADDR_W = 16;  // default RAM address width

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_READ    = 2'd1,
    ST_WRITE   = 2'd2,
    ST_ADVANCE = 2'd3
  } state_e;

endpackage

// File: rtl/commit_time_acc.sv
// -----------------------------------------------------------------------------
// commit_time_acc
// Time accumulator for state_commit. Holds the current time t and the end time,
// advances t by the accepted step with saturation at all-ones, raises the
// sticky finished flag once t reaches the end time, and produces the step fed
// back to the step module.
//
// Configuration macro: STATE_COMMIT_CLAMP_EN
//   defined   : next_step_o = min(step_in_i, t_end - t), 0 once finished
//   undefined : next_step_o = step_in_i
//
// Ports
//   clk, rst      clock, asynchronous active-low reset
//   load_i        load t_i / t_end_i and clear finished (highest priority)
//   t_i, t_end_i  initial time and end time
//   advance_i     commit: t <= sat(t + step_h_i)
//   step_h_i      captured step of the transaction being committed
//   step_in_i     step proposed by the step module (for next_step_o)
//   t_o           current time
//   finished_o    sticky: t has reached t_end
//   next_step_o   step fed back to the step module
// -----------------------------------------------------------------------------
module commit_time_acc
  import state_commit_pkg::*;
#(
  parameter int unsigned WORD_SIZE = WORD_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_i,
  input  logic [WORD_SIZE-1:0] t_i,
  input  logic [WORD_SIZE-1:0] t_end_i,
  input  logic                 advance_i,
  input  logic [WORD_SIZE-1:0] step_h_i,
  input  logic [WORD_SIZE-1:0] step_in_i,
  output logic [WORD_SIZE-1:0] t_o,
  output logic                 finished_o,
  output logic [WORD_SIZE-1:0] next_step_o
);

  logic [WORD_SIZE-1:0] t_q, t_d;
  logic [WORD_SIZE-1:0] t_end_q, t_end_d;
  logic                 finished_q, finished_d;

  // One extra bit catches the carry so the sum can saturate instead of wrap.
  logic [WORD_SIZE:0]   sum_wide;
  logic [WORD_SIZE-1:0] t_adv;

  assign sum_wide = {1'b0, t_q} + {1'b0, step_h_i};
  assign t_adv    = sum_wide[WORD_SIZE] ? {WORD_SIZE{1'b1}} : sum_wide[WORD_SIZE-1:0];

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned, which would otherwise infer a latch.
    t_d        = t_q;
    t_end_d    = t_end_q;
    finished_d = finished_q;
    if (load_i) begin
      t_d        = t_i;
      t_end_d    = t_end_i;
      finished_d = 1'b0;
    end else if (advance_i) begin
      t_d = t_adv;
      if (t_adv >= t_end_q) finished_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    if (!rst) begin
      t_q        <= '0;
      t_end_q    <= '0;
      finished_q <= 1'b0;
    end else begin
      t_q        <= t_d;
      t_end_q    <= t_end_d;
      finished_q <= finished_d;
    end
  end

`ifdef STATE_COMMIT_CLAMP_EN
  // Remaining distance to the end time; zero when t is already at or past it
  // so the subtraction never wraps into a huge step.
  logic [WORD_SIZE-1:0] remaining;
  assign remaining   = (t_end_q > t_q) ? (t_end_q - t_q) : '0;
  assign next_step_o = finished_q ? '0 :
                       ((step_in_i < remaining) ? step_in_i : remaining);
`else
  assign next_step_o = step_in_i;
`endif

  assign t_o        = t_q;
  assign finished_o = finished_q;

endmodule

// File: rtl/state_commit.sv
// -----------------------------------------------------------------------------
// state_commit
// Commits an accepted integration step: copies the candidate state vector
// (x1) over the current one (x0) word by word through a single RAM port, then
// advances time by the accepted step. A rejected step only pulses 'rejected'.
//
// Configuration macro: STATE_COMMIT_CLAMP_EN (step clamping in commit_time_acc)
//
// Ports
//   clk, rst                 clock, asynchronous active-low reset
//   init                     load t_in, t_end_in, n_in, x0/x1 base; clear
//                            finished; aborts any copy in progress
//   start, proceed           step decision pulse and accept(1)/reject(0)
//   step_in                  accepted step h
//   t_in, t_end_in           initial and end time
//   n_in                     state vector length
//   x0_address, x1_address   base of current / candidate vector
//   mem_address, mem_we,
//   mem_wr_data, mem_rd_data RAM port (read data valid one cycle after address)
//   busy, committed,
//   rejected, finished       status flags (committed/rejected are 1-cycle pulses)
//   t_out, next_step         current time and step fed back to the step module
// -----------------------------------------------------------------------------
module state_commit
  import state_commit_pkg::*;
#(
  parameter int unsigned WORD_SIZE    = WORD_W,
  parameter int unsigned ADDRESS_SIZE = ADDR_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    init,
  input  logic                    start,
  input  logic                    proceed,
  input  logic [WORD_SIZE-1:0]    step_in,
  input  logic [WORD_SIZE-1:0]    t_in,
  input  logic [WORD_SIZE-1:0]    t_end_in,
  input  logic [ADDRESS_SIZE-1:0] n_in,
  input  logic [ADDRESS_SIZE-1:0] x0_address,
  input  logic [ADDRESS_SIZE-1:0] x1_address,
  output logic [ADDRESS_SIZE-1:0] mem_address,
  output logic                    mem_we,
  output logic [WORD_SIZE-1:0]    mem_wr_data,
  input  logic [WORD_SIZE-1:0]    mem_rd_data,
  output logic                    busy,
  output logic                    committed,
  output logic                    rejected,
  output logic                    finished,
  output logic [WORD_SIZE-1:0]    t_out,
  output logic [WORD_SIZE-1:0]    next_step
);

  state_e                  state_q, state_d;
  logic [ADDRESS_SIZE-1:0] i_q, i_d;
  logic [ADDRESS_SIZE-1:0] i_inc;
  logic [ADDRESS_SIZE-1:0] n_q, x0_q, x1_q;
  logic [WORD_SIZE-1:0]    h_q, h_d;
  logic                    committed_q, committed_d;
  logic                    rejected_q, rejected_d;
  logic                    advance;
  logic [WORD_SIZE-1:0]    next_step_raw;

  assign i_inc = i_q + ADDRESS_SIZE'(1);

  // FSM and index counter. init overrides everything, including an ADVANCE
  // in flight, so an aborted transaction never commits.
  always_comb begin
    state_d     = state_q;
    i_d         = i_q;
    h_d         = h_q;
    committed_d = 1'b0;
    rejected_d  = 1'b0;
    advance     = 1'b0;
    if (init) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start && !finished) begin
            if (proceed) begin
              h_d     = step_in;
              i_d     = '0;
              state_d = (n_q == '0) ? ST_ADVANCE : ST_READ;
            end else begin
              rejected_d = 1'b1;
            end
          end
        end
        ST_READ:  state_d = ST_WRITE;
        ST_WRITE: begin
          i_d     = i_inc;
          state_d = (i_inc < n_q) ? ST_READ : ST_ADVANCE;
        end
        ST_ADVANCE: begin
          advance     = 1'b1;
          committed_d = 1'b1;
          state_d     = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      i_q         <= '0;
      h_q         <= '0;
      committed_q <= 1'b0;
      rejected_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      i_q         <= i_d;
      h_q         <= h_d;
      committed_q <= committed_d;
      rejected_q  <= rejected_d;
    end
  end

  // Configuration registers, reloaded only by init.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      n_q  <= '0;
      x0_q <= '0;
      x1_q <= '0;
    end else if (init) begin
      n_q  <= n_in;
      x0_q <= x0_address;
      x1_q <= x1_address;
    end
  end

  commit_time_acc #(
    .WORD_SIZE (WORD_SIZE)
  ) u_time_acc (
    .clk         (clk),
    .rst         (rst),
    .load_i      (init),
    .t_i         (t_in),
    .t_end_i     (t_end_in),
    .advance_i   (advance),
    .step_h_i    (h_q),
    .step_in_i   (step_in),
    .t_o         (t_out),
    .finished_o  (finished),
    .next_step_o (next_step_raw)
  );

  // RAM port: address sums wrap naturally at ADDRESS_SIZE bits. The word read
  // in READ arrives during WRITE and is written straight back out.
  always_comb begin
    mem_address = '0;
    mem_we      = 1'b0;
    mem_wr_data = '0;
    unique case (state_q)
      ST_READ:  mem_address = x1_q + i_q;
      ST_WRITE: begin
        mem_address = x0_q + i_q;
        mem_we      = 1'b1;
        mem_wr_data = mem_rd_data;
      end
      default: ;
    endcase
  end

  assign busy      = (state_q != ST_IDLE);
  assign committed = committed_q;
  assign rejected  = rejected_q;
  // next_step can follow step_in combinationally, so it is forced to zero
  // while reset is held to keep every output quiet during reset.
  assign next_step = rst ? next_step_raw : '0;

endmodule
